// File: rtl/mux_tree_pkg.sv
// Shared helpers for the pipelined mux tree: tree depth and legality of the input count.
package mux_tree_pkg;

   function automatic int levels_f(input int n);
      return $clog2(n);
   endfunction

   // Only a power of two of at least 2 builds a complete binary tree.
   function automatic bit num_in_ok_f(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Producer/consumer bundle for mux_tree_pipe: N input words plus select in, one word out.
interface mux_tree_pipe_if
   import mux_tree_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int WIDTH  = 8
);
   localparam int SEL_W = levels_f(NUM_IN);

   logic [WIDTH-1:0] in_data [NUM_IN];
   logic [SEL_W-1:0] sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_data, sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, sel, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/mux_level.sv
// One level of the mux tree: N_IN/2 2:1 muxes steered by sel[0], optionally followed by
// a valid/ready stage register that also carries the select bits still to be consumed.
module mux_level
   import mux_tree_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int WIDTH = 8,
   parameter int PIPE  = 1,
   parameter int SEL_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] up_data [N_IN],
   input  logic [SEL_W-1:0] up_sel,
   input  logic             up_valid,
   output logic             up_ready,
   output logic [WIDTH-1:0] dn_data [N_IN/2],
   output logic [SEL_W-1:0] dn_sel,
   output logic             dn_valid,
   input  logic             dn_ready
);
   localparam int N_OUT = N_IN / 2;

   logic [WIDTH-1:0] mux_data [N_OUT];

   // NOTE: the loop writes every element on every pass, so no latch is inferred.
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         mux_data[j] = up_sel[0] ? up_data[2*j+1] : up_data[2*j];
      end
   end

   if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] q_data [N_OUT];
      logic [SEL_W-1:0] q_sel;
      logic             q_valid;
      logic             ready;

      // Bubbles collapse: an empty stage always accepts, a full one only when drained.
      assign ready = !q_valid || dn_ready;

      // NOTE: non-blocking assignments so every stage samples its upstream pre-edge value.
      // NOTE: the word registers are reset too, so out_data reads 0 after reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q_valid <= 1'b0;
            q_sel   <= '0;
            q_data  <= '{default: '0};
         end else if (ready) begin
            q_valid <= up_valid;
            if (up_valid) begin
               q_sel  <= up_sel >> 1;
               q_data <= mux_data;
            end
         end
      end

      assign up_ready = ready;
      assign dn_valid = q_valid;
      assign dn_data  = q_data;
      assign dn_sel   = q_sel;
   end else begin : g_comb
      logic unused_clk;

      assign up_ready   = dn_ready;
      assign dn_valid   = up_valid;
      assign dn_data    = mux_data;
      assign dn_sel     = up_sel >> 1;
      assign unused_clk = clk ^ rst_n;
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// NUM_IN:1 mux of WIDTH-bit words built from LEVELS chained mux_level stages; level k
// halves the word count and consumes select bit k.
module mux_tree_pipe
   import mux_tree_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int WIDTH  = 8,
   parameter int PIPE   = 1
) (
   input logic           clk,
   input logic           rst_n,
   mux_tree_pipe_if.slave bus
);
   localparam int LEVELS = levels_f(NUM_IN);

   if (!num_in_ok_f(NUM_IN)) begin : g_bad_num_in
      $error("mux_tree_pipe: NUM_IN must be a power of two and at least 2");
   end

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int N_K = NUM_IN >> k;

      logic [WIDTH-1:0]  up_d [N_K];
      logic [LEVELS-1:0] up_s;
      logic              up_v;
      logic              up_r;
      logic [WIDTH-1:0]  dn_d [N_K/2];
      logic [LEVELS-1:0] dn_s;
      logic              dn_v;
      logic              dn_r;

      if (k == 0) begin : g_src
         assign up_d         = bus.in_data;
         assign up_s         = bus.sel;
         assign up_v         = bus.in_valid;
         assign bus.in_ready = up_r;
      end else begin : g_chain
         assign up_d           = g_lvl[k-1].dn_d;
         assign up_s           = g_lvl[k-1].dn_s;
         assign up_v           = g_lvl[k-1].dn_v;
         assign g_lvl[k-1].dn_r = up_r;
      end

      // The last level has consumed every select bit; its leftover select is all zero.
      if (k == LEVELS - 1) begin : g_sink
         logic unused_sel;
         assign bus.out_data  = dn_d[0];
         assign bus.out_valid = dn_v;
         assign dn_r          = bus.out_ready;
         assign unused_sel    = |dn_s;
      end

      mux_level #(
         .N_IN  (N_K),
         .WIDTH (WIDTH),
         .PIPE  (PIPE),
         .SEL_W (LEVELS)
      ) u_level (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_data  (up_d),
         .up_sel   (up_s),
         .up_valid (up_v),
         .up_ready (up_r),
         .dn_data  (dn_d),
         .dn_sel   (dn_s),
         .dn_valid (dn_v),
         .dn_ready (dn_r)
      );
   end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: 8:1 pipelined, 4:1 combinational and 2:1 pipelined instances,
// cycle tables for the corner cases plus a randomized run against a queue-based model.
module tb_mux_tree_pipe;

   localparam int L8 = 3;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   mux_tree_pipe_if #(.NUM_IN(8), .WIDTH(8)) b8 ();
   mux_tree_pipe_if #(.NUM_IN(4), .WIDTH(8)) b4 ();
   mux_tree_pipe_if #(.NUM_IN(2), .WIDTH(8)) b2 ();

   mux_tree_pipe #(.NUM_IN(8), .WIDTH(8), .PIPE(1)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   mux_tree_pipe #(.NUM_IN(4), .WIDTH(8), .PIPE(0)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   mux_tree_pipe #(.NUM_IN(2), .WIDTH(8), .PIPE(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle of the 8:1 instance: inputs driven, outputs expected in that cycle.
   typedef struct {
      logic       iv;
      logic [2:0] sel;
      logic       ordy;
      logic       e_rdy;
      logic       e_vld;
      logic [7:0] e_dat;
      logic       chk;
   } vec_t;

   typedef struct {
      logic [1:0] sel;
      logic       iv;
      logic       ordy;
      logic [7:0] e_dat;
   } cvec_t;

   typedef struct {
      logic [7:0] data;
      int         acc;
   } beat_t;

   vec_t  vecs [$];
   cvec_t cvecs [4];
   beat_t q [$];
   int    cyc;
   logic  acc, emit, exp_rdy, exp_vld;
   logic [7:0] word;

   logic       s2_iv  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic       s2_sel [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   logic       s2_vld [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [7:0] s2_dat [4] = '{8'h00, 8'h5A, 8'hA5, 8'h00};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic iv, input int sel, input logic ordy,
                               input logic rdy, input logic vld, input int dat, input logic chk);
      vec_t v;
      v.iv    = iv;
      v.sel   = sel[2:0];
      v.ordy  = ordy;
      v.e_rdy = rdy;
      v.e_vld = vld;
      v.e_dat = dat[7:0];
      v.chk   = chk;
      vecs.push_back(v);
   endfunction

   function automatic void build_vecs();
      // Single beat sel=5 with out_ready=1: visible 3 cycles after the offer.
      add(1, 5, 1, 1, 0, 'h00, 1);
      add(0, 0, 1, 1, 0, 'h00, 1);
      add(0, 0, 1, 1, 0, 'h00, 1);
      add(0, 0, 1, 1, 1, 'h15, 1);
      add(0, 0, 1, 1, 0, 'h00, 0);
      // Back-to-back sweep of sel 0..7.
      for (int i = 0; i < 8; i++) add(1, i, 1, 1, i >= 3, 'h10 + i - 3, i >= 3);
      for (int i = 8; i < 11; i++) add(0, 0, 1, 1, 1, 'h10 + i - 3, 1);
      add(0, 0, 1, 1, 0, 'h00, 0);
      // Backpressure: 5 offers, 3 accepted, output word stable while stalled.
      add(1, 1, 0, 1, 0, 'h00, 0);
      add(1, 2, 0, 1, 0, 'h00, 0);
      add(1, 3, 0, 1, 0, 'h00, 0);
      add(1, 4, 0, 0, 1, 'h11, 1);
      add(1, 6, 0, 0, 1, 'h11, 1);
      add(0, 0, 1, 1, 1, 'h11, 1);
      add(0, 0, 1, 1, 1, 'h12, 1);
      add(0, 0, 1, 1, 1, 'h13, 1);
      add(0, 0, 1, 1, 0, 'h00, 0);
      // Bubble collapse: one beat, two idle cycles, then stall with two more beats.
      add(1, 7, 1, 1, 0, 'h00, 0);
      add(0, 0, 1, 1, 0, 'h00, 0);
      add(0, 0, 1, 1, 0, 'h00, 0);
      add(1, 0, 0, 1, 1, 'h17, 1);
      add(1, 1, 0, 1, 1, 'h17, 1);
      add(1, 2, 0, 0, 1, 'h17, 1);
      add(0, 0, 1, 1, 1, 'h17, 1);
      add(0, 0, 1, 1, 1, 'h10, 1);
      add(0, 0, 1, 1, 1, 'h11, 1);
      add(0, 0, 1, 1, 0, 'h00, 0);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      b8.in_valid = 1'b0; b8.sel = '0; b8.out_ready = 1'b1;
      b4.in_valid = 1'b0; b4.sel = '0; b4.out_ready = 1'b1;
      b2.in_valid = 1'b0; b2.sel = '0; b2.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) b8.in_data[i] = 8'(16 + i);
      for (int i = 0; i < 4; i++) b4.in_data[i] = 8'(10 + i);
      b2.in_data[0] = 8'hA5;
      b2.in_data[1] = 8'h5A;
      build_vecs();

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst dut8 out_valid", b8.out_valid, 0);
      check("rst dut8 out_data", b8.out_data, 0);
      check("rst dut8 in_ready", b8.in_ready, 1);
      check("rst dut2 out_valid", b2.out_valid, 0);
      check("rst dut2 out_data", b2.out_data, 0);
      check("rst dut2 in_ready", b2.in_ready, 1);

      // Combinational 4:1: table then random words.
      cvecs[0] = '{sel: 2'd2, iv: 1'b1, ordy: 1'b1, e_dat: 8'h0C};
      cvecs[1] = '{sel: 2'd0, iv: 1'b1, ordy: 1'b0, e_dat: 8'h0A};
      cvecs[2] = '{sel: 2'd3, iv: 1'b0, ordy: 1'b1, e_dat: 8'h0D};
      cvecs[3] = '{sel: 2'd1, iv: 1'b0, ordy: 1'b0, e_dat: 8'h0B};
      for (int i = 0; i < 4; i++) begin
         b4.sel = cvecs[i].sel; b4.in_valid = cvecs[i].iv; b4.out_ready = cvecs[i].ordy;
         #1;
         check($sformatf("comb%0d out_data", i), b4.out_data, cvecs[i].e_dat);
         check($sformatf("comb%0d out_valid", i), b4.out_valid, cvecs[i].iv);
         check($sformatf("comb%0d in_ready", i), b4.in_ready, cvecs[i].ordy);
      end
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 4; j++) b4.in_data[j] = 8'($urandom_range(0, 255));
         b4.sel = 2'($urandom_range(0, 3));
         b4.in_valid = 1'($urandom_range(0, 1));
         b4.out_ready = 1'($urandom_range(0, 1));
         #1;
         check("comb rnd out_data", b4.out_data, b4.in_data[b4.sel]);
         check("comb rnd out_valid", b4.out_valid, b4.in_valid);
         check("comb rnd in_ready", b4.in_ready, b4.out_ready);
      end

      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Cycle tables on the 8:1 pipelined instance.
      foreach (vecs[i]) begin
         b8.in_valid = vecs[i].iv; b8.sel = vecs[i].sel; b8.out_ready = vecs[i].ordy;
         @(negedge clk);
         check($sformatf("vec%0d in_ready", i), b8.in_ready, vecs[i].e_rdy);
         check($sformatf("vec%0d out_valid", i), b8.out_valid, vecs[i].e_vld);
         if (vecs[i].chk) check($sformatf("vec%0d out_data", i), b8.out_data, vecs[i].e_dat);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset with three beats in flight.
      b8.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b8.in_valid = 1'b1; b8.sel = 3'(i + 1);
         @(posedge clk);
         #1;
      end
      b8.in_valid = 1'b0;
      @(negedge clk);
      check("arst pre out_valid", b8.out_valid, 1);
      check("arst pre in_ready", b8.in_ready, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst out_valid", b8.out_valid, 0);
      check("arst out_data", b8.out_data, 0);
      check("arst in_ready", b8.in_ready, 1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      b8.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("arst post%0d out_valid", i), b8.out_valid, 0);
      end
      @(posedge clk);
      #1;

      // 2:1 pipelined instance: one cycle of latency.
      for (int i = 0; i < 4; i++) begin
         b2.in_valid = s2_iv[i]; b2.sel = s2_sel[i];
         @(negedge clk);
         check($sformatf("dut2 c%0d in_ready", i), b2.in_ready, 1);
         check($sformatf("dut2 c%0d out_valid", i), b2.out_valid, s2_vld[i]);
         if (s2_vld[i]) check($sformatf("dut2 c%0d out_data", i), b2.out_data, s2_dat[i]);
         @(posedge clk);
         #1;
      end
      b2.in_valid = 1'b0;

      // Randomized run: in-flight beats form a FIFO; the head is visible once it has
      // spent LEVELS cycles (counting its offer cycle), and the input accepts unless
      // LEVELS beats are already held with the consumer stalled.
      cyc = 0;
      for (int n = 0; n < 410; n++) begin
         for (int j = 0; j < 8; j++) b8.in_data[j] = 8'($urandom_range(0, 255));
         b8.sel = 3'($urandom_range(0, 7));
         if (n < 400) begin
            b8.in_valid  = ($urandom_range(0, 9) < 7);
            b8.out_ready = ($urandom_range(0, 9) < 6);
         end else begin
            b8.in_valid  = 1'b0;
            b8.out_ready = 1'b1;
         end
         @(negedge clk);
         exp_rdy = b8.out_ready || (q.size() < L8);
         exp_vld = (q.size() > 0) && (cyc - q[0].acc >= L8 - 1);
         check("rnd in_ready", b8.in_ready, exp_rdy);
         check("rnd out_valid", b8.out_valid, exp_vld);
         if (exp_vld) check("rnd out_data", b8.out_data, q[0].data);
         acc  = b8.in_valid && exp_rdy;
         emit = exp_vld && b8.out_ready;
         word = b8.in_data[b8.sel];
         @(posedge clk);
         cyc++;
         if (emit) void'(q.pop_front());
         if (acc) q.push_back('{data: word, acc: cyc});
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
